gamma_lut_ctrl: RTL and testbench

Configuration controller for the gamma corrector's per-channel lookup tables. Each channel has two LUT banks; this block drives the bank write port. It fills every table with an identity curve after reset. It then accepts host table writes into the shadow bank and swaps the active bank only at a frame boundary, so a frame is never corrected with a half-updated curve.

---
 rtl/gamma_lut_ctrl_if.sv | 31 +++
 rtl/gamma_lut_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_gamma_lut_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_lut_ctrl_if.sv
// Host configuration channel and LUT bank write port of the gamma LUT controller.
// The host (master) issues cfg writes; the controller (slave) drives the LUT write strobe.
interface gamma_lut_ctrl_if #(
    parameter int DW  = 12,
    parameter int AW  = 12,
    parameter int CHW = 2
);
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [AW-1:0]  cfg_addr;
    logic [DW-1:0]  cfg_data;

    logic           lut_we;
    logic           lut_bank;
    logic [CHW-1:0] lut_ch;
    logic [AW-1:0]  lut_addr;
    logic [DW-1:0]  lut_wdata;

    modport master (
        output cfg_valid, cfg_ch, cfg_addr, cfg_data,
        input  cfg_ready,
        input  lut_we, lut_bank, lut_ch, lut_addr, lut_wdata
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_addr, cfg_data,
        output cfg_ready,
        output lut_we, lut_bank, lut_ch, lut_addr, lut_wdata
    );
endinterface

// File: rtl/gamma_lut_ctrl.sv
// Gamma LUT configuration controller: identity fill after reset, host writes into the
// shadow bank, and active-bank swap deferred to the next start-of-frame after a commit.
module gamma_lut_ctrl #(
    parameter int DW  = 12,
    parameter int AW  = 12,
    parameter int NCH = 3,
    parameter int CHW = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            sof,
    input  logic            cfg_commit,
    input  logic            cfg_bypass,
    gamma_lut_ctrl_if.slave bus,
    output logic            act_bank,
    output logic            gamma_bypass,
    output logic            init_done,
    output logic            swap_pending,
    output logic            swap_done,
    output logic            commit_err
);

    localparam int SHL = (DW >= AW) ? DW - AW : 0;
    localparam int SHR = (AW > DW) ? AW - DW : 0;
    localparam logic [CHW:0]   NCH_EXT  = (CHW + 1)'(NCH);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t         state_q, state_d;

    logic [CHW-1:0] fill_ch_q, fill_ch_d;
    logic           fill_bank_q, fill_bank_d;
    logic [AW-1:0]  fill_addr_q, fill_addr_d;

    logic           lut_we_q, lut_we_d;
    logic           lut_bank_q, lut_bank_d;
    logic [CHW-1:0] lut_ch_q, lut_ch_d;
    logic [AW-1:0]  lut_addr_q, lut_addr_d;
    logic [DW-1:0]  lut_wdata_q, lut_wdata_d;

    logic           act_bank_q, act_bank_d;
    logic           gamma_bypass_q, gamma_bypass_d;
    logic           init_done_q, init_done_d;
    logic           swap_done_q, swap_done_d;
    logic           commit_err_q, commit_err_d;

    logic           cfg_ready_c;
    logic           fill_last;
    logic           wr_accept;
    logic           ch_valid;

    // Identity curve: the address rescaled to the entry width.
    function automatic logic [DW-1:0] ident(input logic [AW-1:0] a);
        logic [AW+DW-1:0] w;
        w = {{DW{1'b0}}, a};
        w = (DW >= AW) ? (w << SHL) : (w >> SHR);
        return w[DW-1:0];
    endfunction

    assign fill_last = (state_q == ST_INIT) && (fill_ch_q == LAST_CH) &&
                       fill_bank_q && (&fill_addr_q);
    assign wr_accept = bus.cfg_valid && cfg_ready_c;
    assign ch_valid  = ({1'b0, bus.cfg_ch} < NCH_EXT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_INIT;
            fill_ch_q      <= '0;
            fill_bank_q    <= 1'b0;
            fill_addr_q    <= '0;
            lut_we_q       <= 1'b0;
            lut_bank_q     <= 1'b0;
            lut_ch_q       <= '0;
            lut_addr_q     <= '0;
            lut_wdata_q    <= '0;
            act_bank_q     <= 1'b0;
            gamma_bypass_q <= 1'b0;
            init_done_q    <= 1'b0;
            swap_done_q    <= 1'b0;
            commit_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_ch_q      <= fill_ch_d;
            fill_bank_q    <= fill_bank_d;
            fill_addr_q    <= fill_addr_d;
            lut_we_q       <= lut_we_d;
            lut_bank_q     <= lut_bank_d;
            lut_ch_q       <= lut_ch_d;
            lut_addr_q     <= lut_addr_d;
            lut_wdata_q    <= lut_wdata_d;
            act_bank_q     <= act_bank_d;
            gamma_bypass_q <= gamma_bypass_d;
            init_done_q    <= init_done_d;
            swap_done_q    <= swap_done_d;
            commit_err_q   <= commit_err_d;
        end
    end

    // A sof coinciding with the commit is still seen in IDLE, so the swap waits for the next one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: if (fill_last)  state_d = ST_IDLE;
            ST_IDLE: if (cfg_commit) state_d = ST_PEND;
            ST_PEND: if (sof)        state_d = ST_IDLE;
            default:                 state_d = ST_INIT;
        endcase
    end

    always_comb begin
        cfg_ready_c  = (state_q == ST_IDLE);
        swap_pending = (state_q == ST_PEND);
    end

    always_comb begin
        fill_ch_d      = fill_ch_q;
        fill_bank_d    = fill_bank_q;
        fill_addr_d    = fill_addr_q;
        lut_we_d       = 1'b0;
        lut_bank_d     = lut_bank_q;
        lut_ch_d       = lut_ch_q;
        lut_addr_d     = lut_addr_q;
        lut_wdata_d    = lut_wdata_q;
        act_bank_d     = act_bank_q;
        gamma_bypass_d = gamma_bypass_q;
        init_done_d    = init_done_q;
        swap_done_d    = 1'b0;
        commit_err_d   = 1'b0;

        if (state_q == ST_INIT) begin
            lut_we_d    = 1'b1;
            lut_bank_d  = fill_bank_q;
            lut_ch_d    = fill_ch_q;
            lut_addr_d  = fill_addr_q;
            lut_wdata_d = ident(fill_addr_q);
            fill_addr_d = fill_addr_q + 1'b1;
            if (&fill_addr_q) begin
                fill_bank_d = ~fill_bank_q;
                if (fill_bank_q) fill_ch_d = fill_ch_q + 1'b1;
            end
            if (fill_last) begin
                fill_ch_d   = '0;
                init_done_d = 1'b1;
            end
        end

        // Host writes always target the shadow bank; out-of-range channels are swallowed.
        if (wr_accept && ch_valid) begin
            lut_we_d    = 1'b1;
            lut_bank_d  = ~act_bank_q;
            lut_ch_d    = bus.cfg_ch;
            lut_addr_d  = bus.cfg_addr;
            lut_wdata_d = bus.cfg_data;
        end

        if (state_q != ST_IDLE) commit_err_d = cfg_commit;

        if (state_q == ST_PEND && sof) begin
            act_bank_d     = ~act_bank_q;
            gamma_bypass_d = cfg_bypass;
            swap_done_d    = 1'b1;
        end
    end

    assign bus.cfg_ready = cfg_ready_c;
    assign bus.lut_we    = lut_we_q;
    assign bus.lut_bank  = lut_bank_q;
    assign bus.lut_ch    = lut_ch_q;
    assign bus.lut_addr  = lut_addr_q;
    assign bus.lut_wdata = lut_wdata_q;
    assign act_bank      = act_bank_q;
    assign gamma_bypass  = gamma_bypass_q;
    assign init_done     = init_done_q;
    assign swap_done     = swap_done_q;
    assign commit_err    = commit_err_q;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Scoreboard bench for gamma_lut_ctrl: expected LUT writes are queued as stimulus is
// driven and popped as the controller issues them.
module tb_gamma_lut_ctrl;

    localparam int DW    = 12;
    localparam int AW    = 12;
    localparam int NCH   = 3;
    localparam int CHW   = 2;
    localparam int NFILL = 2 * NCH * (1 << AW);

    typedef struct packed {
        logic           bank;
        logic [CHW-1:0] ch;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;
    } wr_t;

    logic clk;
    logic rstn;
    logic sof;
    logic cfg_commit;
    logic cfg_bypass;
    logic act_bank, gamma_bypass, init_done, swap_pending, swap_done, commit_err;

    int   n_cmp;
    int   n_err;
    logic model_act;
    wr_t  exp_q[$];

    gamma_lut_ctrl_if #(.DW(DW), .AW(AW), .CHW(CHW)) bus ();

    gamma_lut_ctrl #(.DW(DW), .AW(AW), .NCH(NCH), .CHW(CHW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .sof          (sof),
        .cfg_commit   (cfg_commit),
        .cfg_bypass   (cfg_bypass),
        .bus          (bus),
        .act_bank     (act_bank),
        .gamma_bypass (gamma_bypass),
        .init_done    (init_done),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .commit_err   (commit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic wr_t observed();
        return {bus.lut_bank, bus.lut_ch, bus.lut_addr, bus.lut_wdata};
    endfunction

    task automatic test_reset();
        rstn = 1'b0; sof = 1'b0; cfg_commit = 1'b0; cfg_bypass = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
        model_act = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus.lut_we !== 1'b0)       begin n_err++; $display("FAIL rst_lut_we got %b want 0", bus.lut_we); end
        n_cmp++; if (bus.lut_bank !== 1'b0)     begin n_err++; $display("FAIL rst_lut_bank got %b want 0", bus.lut_bank); end
        n_cmp++; if (bus.lut_ch !== '0)         begin n_err++; $display("FAIL rst_lut_ch got %0d want 0", bus.lut_ch); end
        n_cmp++; if (bus.lut_addr !== '0)       begin n_err++; $display("FAIL rst_lut_addr got %h want 0", bus.lut_addr); end
        n_cmp++; if (bus.lut_wdata !== '0)      begin n_err++; $display("FAIL rst_lut_wdata got %h want 0", bus.lut_wdata); end
        n_cmp++; if (bus.cfg_ready !== 1'b0)    begin n_err++; $display("FAIL rst_cfg_ready got %b want 0", bus.cfg_ready); end
        n_cmp++; if (act_bank !== 1'b0)         begin n_err++; $display("FAIL rst_act_bank got %b want 0", act_bank); end
        n_cmp++; if (gamma_bypass !== 1'b0)     begin n_err++; $display("FAIL rst_bypass got %b want 0", gamma_bypass); end
        n_cmp++; if (init_done !== 1'b0)        begin n_err++; $display("FAIL rst_init_done got %b want 0", init_done); end
        n_cmp++; if (swap_pending !== 1'b0)     begin n_err++; $display("FAIL rst_swap_pending got %b want 0", swap_pending); end
        n_cmp++; if (swap_done !== 1'b0)        begin n_err++; $display("FAIL rst_swap_done got %b want 0", swap_done); end
        n_cmp++; if (commit_err !== 1'b0)       begin n_err++; $display("FAIL rst_commit_err got %b want 0", commit_err); end
    endtask

    task automatic test_init_fill();
        int  highs = 0;
        bit  started = 0;
        bit  ended = 0;
        bit  ready_bad = 0;
        wr_t obs, exp;
        for (int c = 0; c < NCH; c++)
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < (1 << AW); a++)
                    exp_q.push_back({b[0], c[CHW-1:0], a[AW-1:0], a[DW-1:0]});
        rstn = 1'b1;
        for (int i = 0; i < NFILL + 40 && !ended; i++) begin
            tick();
            if (i == 0) begin
                n_cmp++; if (bus.lut_we !== 1'b1) begin n_err++; $display("FAIL fill_first_cycle lut_we got %b want 1", bus.lut_we); end
            end
            if (i == 50) begin
                n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL fill_init_done_early got %b want 0", init_done); end
            end
            if (i == 101) begin
                n_cmp++; if (commit_err !== 1'b1) begin n_err++; $display("FAIL init_commit_err got %b want 1", commit_err); end
                n_cmp++; if (act_bank !== 1'b0)   begin n_err++; $display("FAIL init_commit_act got %b want 0", act_bank); end
                cfg_commit = 1'b0;
            end
            if (i == 100) cfg_commit = 1'b1;
            if (i < NFILL - 100 && bus.cfg_ready !== 1'b0) ready_bad = 1;
            if (i == 300) sof = 1'b1;
            if (i == 301) sof = 1'b0;
            if (bus.lut_we === 1'b1) begin
                highs++;
                started = 1;
                obs = observed();
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL fill_extra_write got %h want none", obs);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin n_err++; $display("FAIL fill_entry got %h want %h", obs, exp); end
                end
                if (obs.ch == 0 && obs.bank == 1'b0 && obs.addr == 12'h000) begin
                    n_cmp++; if (obs.data !== 12'h000) begin n_err++; $display("FAIL spot_c0b0a0 got %h want 000", obs.data); end
                end
                if (obs.ch == 2 && obs.bank == 1'b1 && obs.addr == 12'hFFF) begin
                    n_cmp++; if (obs.data !== 12'hFFF) begin n_err++; $display("FAIL spot_c2b1aFFF got %h want FFF", obs.data); end
                end
                if (obs.ch == 1 && obs.bank == 1'b0 && obs.addr == 12'h800) begin
                    n_cmp++; if (obs.data !== 12'h800) begin n_err++; $display("FAIL spot_c1b0a800 got %h want 800", obs.data); end
                end
            end else if (started) begin
                ended = 1;
                n_cmp++; if (highs != NFILL)         begin n_err++; $display("FAIL fill_length got %0d want %0d", highs, NFILL); end
                n_cmp++; if (init_done !== 1'b1)     begin n_err++; $display("FAIL fill_init_done got %b want 1", init_done); end
                n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL fill_cfg_ready got %b want 1", bus.cfg_ready); end
                n_cmp++; if (exp_q.size() != 0)      begin n_err++; $display("FAIL fill_missing got %0d want 0", exp_q.size()); end
            end
        end
        n_cmp++; if (!ended)    begin n_err++; $display("FAIL fill_timeout got %0d writes want %0d", highs, NFILL); end
        n_cmp++; if (ready_bad) begin n_err++; $display("FAIL fill_cfg_ready_during_init got 1 want 0"); end
        exp_q.delete();
    endtask

    task automatic test_host_write();
        wr_t obs, exp;
        n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL hw_ready got %b want 1", bus.cfg_ready); end
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_addr = 12'h010; bus.cfg_data = 12'hABC;
        exp_q.push_back({~model_act, 2'd1, 12'h010, 12'hABC});
        tick();
        bus.cfg_valid = 1'b0;
        n_cmp++; if (bus.lut_we !== 1'b1) begin n_err++; $display("FAIL hw_we got %b want 1", bus.lut_we); end
        if (bus.lut_we === 1'b1 && exp_q.size() > 0) begin
            obs = observed(); exp = exp_q.pop_front();
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL hw_entry got %h want %h", obs, exp); end
        end
        n_cmp++; if (act_bank !== 1'b0) begin n_err++; $display("FAIL hw_act_bank got %b want 0", act_bank); end
        tick();
        n_cmp++; if (bus.lut_we !== 1'b0) begin n_err++; $display("FAIL hw_we_after got %b want 0", bus.lut_we); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [CHW-1:0] chs[6] = '{2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic           exp_we;
        wr_t            obs, exp;
        for (int i = 0; i < 6; i++) begin
            a = AW'($urandom); d = DW'($urandom);
            bus.cfg_valid = 1'b1; bus.cfg_ch = chs[i]; bus.cfg_addr = a; bus.cfg_data = d;
            exp_we = (chs[i] < 2'(NCH));
            if (exp_we) exp_q.push_back({~model_act, chs[i], a, d});
            tick();
            n_cmp++; if (bus.lut_we !== exp_we) begin n_err++; $display("FAIL b2b_we[%0d] got %b want %b", i, bus.lut_we, exp_we); end
            if (bus.lut_we === 1'b1 && exp_q.size() > 0) begin
                obs = observed(); exp = exp_q.pop_front();
                n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_entry[%0d] got %h want %h", i, obs, exp); end
            end
        end
        bus.cfg_valid = 1'b0;
        tick();
        n_cmp++; if (bus.lut_we !== 1'b0) begin n_err++; $display("FAIL b2b_idle_we got %b want 0", bus.lut_we); end
        n_cmp++; if (exp_q.size() != 0)   begin n_err++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_commit_swap();
        wr_t obs, exp;
        bit  bad = 0;
        cfg_commit = 1'b1; cfg_bypass = 1'b1;
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_addr = 12'h005; bus.cfg_data = 12'h123;
        exp_q.push_back({~model_act, 2'd0, 12'h005, 12'h123});
        tick();
        cfg_commit = 1'b0; bus.cfg_valid = 1'b0;
        n_cmp++; if (bus.lut_we !== 1'b1) begin n_err++; $display("FAIL cs_write_we got %b want 1", bus.lut_we); end
        if (bus.lut_we === 1'b1 && exp_q.size() > 0) begin
            obs = observed(); exp = exp_q.pop_front();
            n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL cs_write_entry got %h want %h", obs, exp); end
        end
        n_cmp++; if (swap_pending !== 1'b1)  begin n_err++; $display("FAIL cs_pending got %b want 1", swap_pending); end
        n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL cs_ready got %b want 0", bus.cfg_ready); end
        n_cmp++; if (act_bank !== 1'b0)      begin n_err++; $display("FAIL cs_act_early got %b want 0", act_bank); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (swap_pending !== 1'b1 || act_bank !== 1'b0 || bus.lut_we !== 1'b0 || gamma_bypass !== 1'b0) bad = 1;
        end
        n_cmp++; if (bad) begin n_err++; $display("FAIL cs_hold got changed want pending/act0/bypass0"); end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        model_act = ~model_act;
        n_cmp++; if (act_bank !== model_act)  begin n_err++; $display("FAIL cs_act got %b want %b", act_bank, model_act); end
        n_cmp++; if (gamma_bypass !== 1'b1)   begin n_err++; $display("FAIL cs_bypass got %b want 1", gamma_bypass); end
        n_cmp++; if (swap_done !== 1'b1)      begin n_err++; $display("FAIL cs_swap_done got %b want 1", swap_done); end
        n_cmp++; if (swap_pending !== 1'b0)   begin n_err++; $display("FAIL cs_pending_clr got %b want 0", swap_pending); end
        n_cmp++; if (bus.cfg_ready !== 1'b1)  begin n_err++; $display("FAIL cs_ready_back got %b want 1", bus.cfg_ready); end
        tick();
        n_cmp++; if (swap_done !== 1'b0)      begin n_err++; $display("FAIL cs_swap_done_pulse got %b want 0", swap_done); end
        cfg_bypass = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sof = (i == 2);
            tick();
        end
        sof = 1'b0;
        n_cmp++; if (gamma_bypass !== 1'b1)  begin n_err++; $display("FAIL cs_bypass_nocommit got %b want 1", gamma_bypass); end
        n_cmp++; if (act_bank !== model_act) begin n_err++; $display("FAIL cs_act_nocommit got %b want %b", act_bank, model_act); end
        bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd2; bus.cfg_addr = 12'hFFF; bus.cfg_data = 12'h001;
        exp_q.push_back({~model_act, 2'd2, 12'hFFF, 12'h001});
        tick();
        bus.cfg_valid = 1'b0;
        if (exp_q.size() > 0) begin
            obs = observed(); exp = exp_q.pop_front();
            n_cmp++; if (bus.lut_we !== 1'b1 || obs !== exp) begin n_err++; $display("FAIL cs_shadow_write got we=%b %h want we=1 %h", bus.lut_we, obs, exp); end
        end
        tick();
        exp_q.delete();
    endtask

    task automatic test_commit_sof_same();
        bit we_bad = 0;
        cfg_commit = 1'b1; sof = 1'b1; cfg_bypass = 1'b0;
        tick();
        cfg_commit = 1'b0; sof = 1'b0;
        n_cmp++; if (swap_pending !== 1'b1)  begin n_err++; $display("FAIL same_pending got %b want 1", swap_pending); end
        n_cmp++; if (act_bank !== model_act) begin n_err++; $display("FAIL same_act got %b want %b", act_bank, model_act); end
        n_cmp++; if (swap_done !== 1'b0)     begin n_err++; $display("FAIL same_swap_done got %b want 0", swap_done); end
        for (int j = 1; j <= 9; j++) begin
            tick();
            if (j == 4) begin
                n_cmp++; if (commit_err !== 1'b1)   begin n_err++; $display("FAIL pend_commit_err got %b want 1", commit_err); end
                n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL pend_commit_pending got %b want 1", swap_pending); end
                n_cmp++; if (act_bank !== model_act) begin n_err++; $display("FAIL pend_commit_act got %b want %b", act_bank, model_act); end
                cfg_commit = 1'b0;
            end
            if (bus.lut_we !== 1'b0) we_bad = 1;
            if (j == 3) cfg_commit = 1'b1;
            if (j == 5) begin
                bus.cfg_valid = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_addr = 12'h0AA; bus.cfg_data = 12'h555;
            end
            if (j == 7) bus.cfg_valid = 1'b0;
        end
        n_cmp++; if (we_bad) begin n_err++; $display("FAIL pend_write_blocked got lut_we=1 want 0"); end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        model_act = ~model_act;
        n_cmp++; if (act_bank !== model_act) begin n_err++; $display("FAIL same_late_act got %b want %b", act_bank, model_act); end
        n_cmp++; if (swap_done !== 1'b1)     begin n_err++; $display("FAIL same_late_done got %b want 1", swap_done); end
        n_cmp++; if (gamma_bypass !== 1'b0)  begin n_err++; $display("FAIL same_late_bypass got %b want 0", gamma_bypass); end
        tick();
    endtask

    task automatic test_reset_midop();
        int  highs = 0;
        bit  started = 0;
        bit  ended = 0;
        wr_t obs;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0; sof = 1'b1;
        tick();
        sof = 1'b0;
        model_act = ~model_act;
        n_cmp++; if (act_bank !== 1'b1) begin n_err++; $display("FAIL rm_setup_act got %b want 1", act_bank); end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL rm_setup_pending got %b want 1", swap_pending); end
        rstn = 1'b0;
        #1;
        model_act = 1'b0;
        n_cmp++; if (act_bank !== 1'b0)      begin n_err++; $display("FAIL rm_act got %b want 0", act_bank); end
        n_cmp++; if (swap_pending !== 1'b0)  begin n_err++; $display("FAIL rm_pending got %b want 0", swap_pending); end
        n_cmp++; if (init_done !== 1'b0)     begin n_err++; $display("FAIL rm_init_done got %b want 0", init_done); end
        n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready got %b want 0", bus.cfg_ready); end
        n_cmp++; if (bus.lut_we !== 1'b0)    begin n_err++; $display("FAIL rm_we got %b want 0", bus.lut_we); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < NFILL + 40 && !ended; i++) begin
            tick();
            if (bus.lut_we === 1'b1) begin
                if (!started) begin
                    obs = observed();
                    n_cmp++; if (obs !== '0) begin n_err++; $display("FAIL rm_first_entry got %h want 0", obs); end
                end
                started = 1;
                highs++;
            end else if (started) begin
                ended = 1;
                n_cmp++; if (highs != NFILL)         begin n_err++; $display("FAIL rm_fill_length got %0d want %0d", highs, NFILL); end
                n_cmp++; if (act_bank !== model_act) begin n_err++; $display("FAIL rm_act_after got %b want %b", act_bank, model_act); end
                n_cmp++; if (init_done !== 1'b1)     begin n_err++; $display("FAIL rm_init_done_after got %b want 1", init_done); end
            end
        end
        n_cmp++; if (!ended) begin n_err++; $display("FAIL rm_timeout got %0d writes want %0d", highs, NFILL); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_init_fill();
        test_host_write();
        test_back_to_back();
        test_commit_swap();
        test_commit_sof_same();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
